// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Contents:
//   state_e    - loader FSM state encoding (3 bit)
//   WORD_BYTES - bytes packed into each memory word
//   BYTE_W, WORD_W, LEN_W, CHK_W, BYTE_CNT_W - frame and datapath field widths
package loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned LEN_W      = 8;  // LEN field holds word count minus one
  localparam int unsigned CHK_W      = 8;  // modular byte sum
  localparam int unsigned BYTE_CNT_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
    StCheck = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer for the program loader.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   clear      - restart packing at byte 0 (start of a new frame)
//   shift      - accept data this cycle
//   data       - incoming byte
//   word_next  - word formed by the held bytes plus the current data byte
//   word_valid - shift is on the last byte of a word; word_next is then complete
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_next,
  output logic              word_valid
);

  localparam int unsigned HoldW = WORD_W - BYTE_W;

  // Only the three earlier bytes are stored; the fourth comes straight from data so the
  // parent can register the full word on the same edge that accepts the last byte.
  logic [HoldW-1:0]      hold_q;
  logic [BYTE_CNT_W-1:0] cnt_q;

  always_comb begin
    word_next  = {hold_q, data};
    word_valid = shift && (cnt_q == BYTE_CNT_W'(WORD_BYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (shift) begin
      hold_q <= word_next[HoldW-1:0];
      cnt_q  <= cnt_q + BYTE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a framed byte stream (LEN, 4*(LEN+1) payload bytes
// MSB first, CHK), writes each packed word to consecutive memory words starting at
// BASE_ADDR and checks CHK against the modular sum of LEN and payload bytes.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - single-cycle load request (honoured in idle/done/err only)
//   in_valid, in_data - byte stream; in_ready is the loader's accept
//   mem_we/addr/din   - memory write port, owned by the loader while cpu_hold=1
//   cpu_hold          - holds the CPU in reset
//   done, err         - result of the last completed load
// All outputs are registered.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned CmpW = (CntW > LEN_W) ? CntW : LEN_W;

  state_e            state_q;
  logic [LEN_W-1:0]  last_idx_q;  // N-1
  logic [CntW-1:0]   word_idx_q;
  logic [CHK_W-1:0]  sum_q;

  logic              hs;
  logic              load_start;
  logic              last_word;
  logic              pack_shift;
  logic              word_valid;
  logic [WORD_W-1:0] word_next;

  always_comb begin
    hs         = in_valid && in_ready;
    load_start = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    last_word  = CmpW'(word_idx_q) == CmpW'(last_idx_q);
    pack_shift = hs && (state_q == StData);
  end

  byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .shift      (pack_shift),
    .data       (in_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_idx_q <= '0;
      word_idx_q <= '0;
      sum_q      <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StLen;
            word_idx_q <= '0;
            sum_q      <= '0;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        StLen: begin
          if (hs) begin
            last_idx_q <= in_data;
            sum_q      <= sum_q + in_data;
            state_q    <= StData;
          end
        end
        StData: begin
          if (hs) begin
            sum_q <= sum_q + in_data;
            if (word_valid) begin
              // Register the write here so mem_we/addr/din are all valid in StWrite.
              state_q  <= StWrite;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_addr <= ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];
              mem_din  <= word_next;
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + CntW'(1);
          in_ready   <= 1'b1;
          state_q    <= last_word ? StCheck : StData;
        end
        StCheck: begin
          if (hs) begin
            in_ready <= 1'b0;
            if (in_data == sum_q) begin
              state_q  <= StDone;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two instances share one stimulus stream:
// dut 0 loads at BASE_ADDR 0, dut 1 at BASE_ADDR 254 so every frame of 3+ words also
// exercises address wrap. Expected writes and results come from a frame-level model.
module tb_program_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_valid;
  logic [7:0] in_data;

  logic        rdy_w  [2];
  logic        we_w   [2];
  logic [7:0]  addr_w [2];
  logic [31:0] din_w  [2];
  logic        hold_w [2];
  logic        done_w [2];
  logic        err_w  [2];

  int tests = 0;
  int fails = 0;

  wr_t        wq0[$];
  wr_t        wq1[$];
  logic [1:0] rq0[$];  // {done, err}
  logic [1:0] rq1[$];
  logic [7:0] payload[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_w[0]), .mem_we(we_w[0]), .mem_addr(addr_w[0]), .mem_din(din_w[0]),
    .cpu_hold(hold_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  program_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_w[1]), .mem_we(we_w[1]), .mem_addr(addr_w[1]), .mem_din(din_w[1]),
    .cpu_hold(hold_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT writes or reports a result.
  logic we_prev  [2] = '{1'b0, 1'b0};
  logic res_prev [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we_w[d]) begin
        wr_t e;
        chk($sformatf("we_one_cycle[%0d]", d), 64'(we_prev[d]), 64'd0);
        chk($sformatf("ready_low_in_write[%0d]", d), 64'(rdy_w[d]), 64'd0);
        if ((d == 0 && wq0.size() == 0) || (d == 1 && wq1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write[%0d]: got addr %0h data %0h, expected none",
                   d, addr_w[d], din_w[d]);
        end else begin
          e = (d == 0) ? wq0.pop_front() : wq1.pop_front();
          chk($sformatf("write_addr[%0d]", d), 64'(addr_w[d]), 64'(e.addr));
          chk($sformatf("write_data[%0d]", d), 64'(din_w[d]), 64'(e.data));
        end
      end
      we_prev[d] = we_w[d];
      if ((done_w[d] || err_w[d]) && !res_prev[d]) begin
        logic [1:0] r;
        if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result[%0d]: got done %0b err %0b, expected none",
                   d, done_w[d], err_w[d]);
        end else begin
          r = (d == 0) ? rq0.pop_front() : rq1.pop_front();
          chk($sformatf("result_done_err[%0d]", d), 64'({done_w[d], err_w[d]}), 64'(r));
          // CPU is released only on a good load.
          chk($sformatf("result_hold[%0d]", d), 64'(hold_w[d]), 64'(r[0]));
        end
      end
      res_prev[d] = done_w[d] || err_w[d];
    end
  end

  function automatic logic [31:0] model_word(input int w);
    return {payload[4*w], payload[4*w+1], payload[4*w+2], payload[4*w+3]};
  endfunction

  function automatic logic [7:0] model_sum();
    int s;
    s = payload.size() / 4 - 1;
    foreach (payload[i]) s += int'(payload[i]);
    return 8'(s % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (rdy_w[0]) break;
      waited++;
      if (waited > 50) begin
        tests++;
        fails++;
        $display("FAIL byte_accept_timeout: got in_ready 0, expected 1 within 50 cycles");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_drain(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (wq0.size() + wq1.size() + rq0.size() + rq1.size() == 0) break;
      tick();
    end
    chk("scoreboard_drained", 64'(wq0.size() + wq1.size() + rq0.size() + rq1.size()), 64'd0);
  endtask

  // Sends LEN, payload and chk. abort: reset after the 6th payload byte (needs >= 2 words).
  task automatic run_frame(input logic [7:0] chk_byte, input bit gaps, input bit start_mid,
                           input bit abort);
    int   n;
    int   nw;
    bit   ok;
    n  = payload.size() / 4;
    ok = (chk_byte == model_sum());
    nw = abort ? 1 : n;
    for (int w = 0; w < nw; w++) begin
      wq0.push_back('{addr: 8'(w), data: model_word(w)});
      wq1.push_back('{addr: 8'((254 + w) % 256), data: model_word(w)});
    end
    if (!abort) begin
      rq0.push_back({ok, !ok});
      rq1.push_back({ok, !ok});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("start_hold[%0d]", d), 64'(hold_w[d]), 64'd1);
      chk($sformatf("start_ready[%0d]", d), 64'(rdy_w[d]), 64'd1);
      chk($sformatf("start_clears[%0d]", d), 64'({done_w[d], err_w[d]}), 64'd0);
    end
    send_byte(8'(n - 1), gaps);
    for (int i = 0; i < payload.size(); i++) begin
      send_byte(payload[i], gaps);
      if (start_mid && i == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (abort && i == 5) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("abort_hold[%0d]", d), 64'(hold_w[d]), 64'd1);
          chk($sformatf("abort_ready[%0d]", d), 64'(rdy_w[d]), 64'd0);
          chk($sformatf("abort_we[%0d]", d), 64'(we_w[d]), 64'd0);
          chk($sformatf("abort_done_err[%0d]", d), 64'({done_w[d], err_w[d]}), 64'd0);
        end
        wait_drain(10);
        return;
      end
    end
    send_byte(chk_byte, gaps);
    wait_drain(20);
  endtask

  task automatic fill_payload(input int n_words);
    payload.delete();
    for (int i = 0; i < 4 * n_words; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready[%0d]", d), 64'(rdy_w[d]), 64'd0);
      chk($sformatf("rst_we[%0d]", d), 64'(we_w[d]), 64'd0);
      chk($sformatf("rst_addr[%0d]", d), 64'(addr_w[d]), 64'd0);
      chk($sformatf("rst_din[%0d]", d), 64'(din_w[d]), 64'd0);
      chk($sformatf("rst_hold[%0d]", d), 64'(hold_w[d]), 64'd1);
      chk($sformatf("rst_done_err[%0d]", d), 64'({done_w[d], err_w[d]}), 64'd0);
    end
    start = 1'b1;  // start together with reset must lose
    tick();
    start = 1'b0;
    chk("rst_beats_start", 64'(rdy_w[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Single word DEADBEEF: LEN + payload sums to 0x38.
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(8'h38, 1'b0, 1'b0, 1'b0);

    // Bytes offered outside a frame are refused.
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_ready_low", 64'(rdy_w[0]), 64'd0);
    end
    in_valid = 1'b0;

    // Bad checksums: write still happens, err set, CPU kept held.
    run_frame(8'h39, 1'b0, 1'b0, 1'b0);
    run_frame(8'h78, 1'b0, 1'b0, 1'b0);

    // Two words with valid gaps.
    payload = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_frame(model_sum(), 1'b1, 1'b0, 1'b0);

    // Four words: dut1 writes 254, 255, 0, 1.
    fill_payload(4);
    run_frame(model_sum(), 1'b0, 1'b0, 1'b0);

    // Reset after the 6th payload byte, then a clean reload.
    fill_payload(3);
    run_frame(model_sum(), 1'b0, 1'b0, 1'b1);
    fill_payload(3);
    run_frame(model_sum(), 1'b1, 1'b0, 1'b0);

    // Start pulsed mid-word is ignored.
    fill_payload(2);
    run_frame(model_sum(), 1'b0, 1'b1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      logic [7:0] c;
      fill_payload(int'($urandom_range(1, 6)));
      c = model_sum();
      if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
      run_frame(c, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    repeat (5) tick();
    wait_drain(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
